// File: rtl/wb_timer_if.sv
// ---------------------------------------------------------------------------
// wb_timer_if
//   Wishbone classic single-transfer bus bundle between the OBI-to-Wishbone
//   bridge (master) and the timer peripheral (slave).
//
//   Signals (named from the slave's point of view):
//     wb_cyc_i     : bus cycle active
//     wb_stb_i     : transfer strobe
//     wb_addr_i    : byte address
//     wb_wr_en_i   : 1 = write, 0 = read
//     wb_byte_en_i : per-byte write enable
//     wb_wdata_i   : write data
//     wb_rdata_o   : read data, valid while wb_ack_o is high, 0 otherwise
//     wb_ack_o     : one-cycle transfer acknowledge
// ---------------------------------------------------------------------------
interface wb_timer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  wb_cyc_i;
   logic                  wb_stb_i;
   logic [ADDR_W-1:0]     wb_addr_i;
   logic                  wb_wr_en_i;
   logic [DATA_W/8-1:0]   wb_byte_en_i;
   logic [DATA_W-1:0]     wb_wdata_i;
   logic [DATA_W-1:0]     wb_rdata_o;
   logic                  wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_addr_i, wb_wr_en_i, wb_byte_en_i, wb_wdata_i,
      input  wb_rdata_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_addr_i, wb_wr_en_i, wb_byte_en_i, wb_wdata_i,
      output wb_rdata_o, wb_ack_o
   );
endinterface

// File: rtl/wb_timer.sv
// ---------------------------------------------------------------------------
// wb_timer
//   Wishbone classic slave timer: prescaled 32-bit up-counter, compare
//   register with optional auto-reload, and a level interrupt.
//
//   Ports:
//     wb_clk_i : clock, rising edge
//     rst_i    : asynchronous active-high reset
//     bus      : Wishbone slave bundle (wb_timer_if.slave)
//     irq_o    : level interrupt, MATCH & IE
//
//   Register map (byte offset, decoded on addr[4:2]):
//     0x00 CTRL   : bit0 EN, bit1 AR, bit2 IE
//     0x04 PRESC  : [PRESC_W-1:0], counter advances every PRESC+1 clocks
//     0x08 COUNT  : 32-bit counter
//     0x0C CMP    : 32-bit compare value
//     0x10 STATUS : bit0 MATCH, write-1-to-clear
//     0x14..0x1C  : unmapped, read 0, writes dropped, still acknowledged
//
//   DATA_W is fixed at 32 for this block.
// ---------------------------------------------------------------------------
module wb_timer #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int PRESC_W = 16
) (
   input  logic        wb_clk_i,
   input  logic        rst_i,
   wb_timer_if.slave   bus,
   output logic        irq_o
);

   localparam int NB = DATA_W / 8;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } bus_state_e;

   // ------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------
   bus_state_e           state_q, state_d;
   logic                 en_q, ar_q, ie_q;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [PRESC_W-1:0]   pcnt_q, pcnt_d;
   logic [DATA_W-1:0]    count_q, count_d;
   logic [DATA_W-1:0]    cmp_q, cmp_d;
   logic                 match_q, match_d;
   logic [DATA_W-1:0]    rdata_q;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0]    addr;
   logic [2:0]           reg_sel;
   logic                 req, take, wr, rd;
   logic                 wr_ctrl, wr_presc, wr_count, wr_cmp, w1c_match;
   logic                 unused_addr;

   assign addr    = bus.wb_addr_i;
   assign reg_sel = addr[4:2];
   assign unused_addr = ^{addr[ADDR_W-1:5], addr[1:0]};

   assign req  = bus.wb_cyc_i & bus.wb_stb_i;
   // Requests are only taken in IDLE; the strobe still high during ACK is
   // ignored so a single request cannot be acknowledged twice.
   assign take = (state_q == S_IDLE) & req;
   assign wr   = take &  bus.wb_wr_en_i;
   assign rd   = take & ~bus.wb_wr_en_i;

   // CTRL and STATUS only have bits in byte 0.
   assign wr_ctrl   = wr & (reg_sel == 3'd0) & bus.wb_byte_en_i[0];
   assign wr_presc  = wr & (reg_sel == 3'd1);
   assign wr_count  = wr & (reg_sel == 3'd2);
   assign wr_cmp    = wr & (reg_sel == 3'd3);
   assign w1c_match = wr & (reg_sel == 3'd4) & bus.wb_byte_en_i[0] & bus.wb_wdata_i[0];

   function automatic logic [DATA_W-1:0] byte_merge(
      input logic [DATA_W-1:0] old_v,
      input logic [DATA_W-1:0] new_v,
      input logic [NB-1:0]     be
   );
      logic [DATA_W-1:0] r;
      r = old_v;
      for (int b = 0; b < NB; b++) begin
         if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Bus slave FSM
   // ------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req) state_d = S_ACK;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.wb_ack_o   = (state_q == S_ACK);
   assign bus.wb_rdata_o = rdata_q;

   // ------------------------------------------------------------------
   // Read mux (register state just before the sampling edge)
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         3'd0:    rd_mux[2:0]         = {ie_q, ar_q, en_q};
         3'd1:    rd_mux[PRESC_W-1:0] = presc_q;
         3'd2:    rd_mux              = count_q;
         3'd3:    rd_mux              = cmp_q;
         3'd4:    rd_mux[0]           = match_q;
         default: rd_mux              = '0;
      endcase
   end

   // Read data lives only for the ACK cycle; every other cycle it is 0.
   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i)   rdata_q <= '0;
      else if (rd) rdata_q <= rd_mux;
      else         rdata_q <= '0;
   end

   // ------------------------------------------------------------------
   // Tick generation
   // ------------------------------------------------------------------
   logic presc_hit, en_clr, tick, cmp_hit;

   assign presc_hit = (pcnt_q == presc_q);
   // A write that turns EN off cancels the tick on that same edge.
   assign en_clr    = wr_ctrl & ~bus.wb_wdata_i[0];
   // Tick uses the pre-write EN/PRESC, so new values apply a cycle later.
   assign tick      = en_q & presc_hit & ~en_clr;
   assign cmp_hit   = (count_q == cmp_q);

   always_comb begin
      pcnt_d = pcnt_q + 1'b1;
      if (!en_q || en_clr || presc_hit) pcnt_d = '0;
   end

   always_comb begin
      presc_d = presc_q;
      if (wr_presc) begin
         for (int i = 0; i < PRESC_W; i++) begin
            if (bus.wb_byte_en_i[i/8]) presc_d[i] = bus.wb_wdata_i[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Counter, compare, match
   // ------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      if (wr_count)
         count_d = byte_merge(count_q, bus.wb_wdata_i, bus.wb_byte_en_i);
      else if (tick)
         count_d = (cmp_hit && ar_q) ? '0 : count_q + 1'b1;
   end

   always_comb begin
      cmp_d = cmp_q;
      if (wr_cmp) cmp_d = byte_merge(cmp_q, bus.wb_wdata_i, bus.wb_byte_en_i);
   end

   // Set beats clear when a match lands on the same edge as the W1C.
   always_comb begin
      match_d = match_q;
      if (tick && cmp_hit) match_d = 1'b1;
      else if (w1c_match)  match_d = 1'b0;
   end

   always_ff @(posedge wb_clk_i or posedge rst_i) begin
      if (rst_i) begin
         en_q    <= 1'b0;
         ar_q    <= 1'b0;
         ie_q    <= 1'b0;
         presc_q <= '0;
         pcnt_q  <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         match_q <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en_q <= bus.wb_wdata_i[0];
            ar_q <= bus.wb_wdata_i[1];
            ie_q <= bus.wb_wdata_i[2];
         end
         presc_q <= presc_d;
         pcnt_q  <= pcnt_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         match_q <= match_d;
      end
   end

   assign irq_o = match_q & ie_q;

endmodule

// File: tb/tb_wb_timer.sv
module tb_wb_timer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic irq;

   always #5 clk = ~clk;

   wb_timer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   wb_timer #(.ADDR_W(32), .DATA_W(32), .PRESC_W(16)) dut (
      .wb_clk_i (clk),
      .rst_i    (rst),
      .bus      (bus.slave),
      .irq_o    (irq)
   );

   typedef struct {
      bit          is_rd;
      logic [7:0]  addr;
      logic [31:0] exp;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   logic irq_at_ack;
   logic prev_ack = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that
   // ends the ack cycle. Strobe is sampled at the first edge.
   task automatic xfer(input bit we, input logic [7:0] a, input logic [3:0] be,
                       input logic [31:0] d, input logic [31:0] exp);
      exp_t e;
      e.is_rd = !we; e.addr = a; e.exp = exp;
      sbq.push_back(e);
      bus.wb_cyc_i     = 1'b1;
      bus.wb_stb_i     = 1'b1;
      bus.wb_wr_en_i   = we;
      bus.wb_addr_i    = {24'h0, a};
      bus.wb_byte_en_i = be;
      bus.wb_wdata_i   = d;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      @(negedge clk);
      chk($sformatf("ack_latency_%02h", a), {31'b0, bus.wb_ack_o}, 32'd1);
      irq_at_ack = irq;
      @(posedge clk); #1;
   endtask

   task automatic wr32(input logic [7:0] a, input logic [31:0] d);
      xfer(1'b1, a, 4'hF, d, 32'h0);
   endtask

   task automatic rd32(input logic [7:0] a, input logic [31:0] exp);
      xfer(1'b0, a, 4'h0, 32'h0, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Counts falling edges until irq is seen high; 1 = state right after
   // the first edge following the call. Realigns to just after a rise.
   task automatic wait_irq(input string nm, input int exp_k);
      int k;
      k = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (irq) begin k = i; break; end
      end
      if (k == 0) begin
         checks++; failures++;
         $display("FAIL %s: irq timeout got none want %0d cycles", nm, exp_k);
      end else chk(nm, k, exp_k);
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: pops an expectation on every ack.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.wb_ack_o) begin
            chk("ack_width", {31'b0, prev_ack}, 32'd0);
            if (sbq.size() == 0) chk("ack_spurious", 32'd0, 32'd1);
            else begin
               e = sbq.pop_front();
               if (e.is_rd) chk($sformatf("rd_%02h", e.addr), bus.wb_rdata_o, e.exp);
            end
         end else begin
            chk("rdata_idle", bus.wb_rdata_o, 32'h0);
         end
      end
      prev_ack = bus.wb_ack_o;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_wr_en_i = 0;
      bus.wb_addr_i = '0; bus.wb_byte_en_i = '0; bus.wb_wdata_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", {31'b0, bus.wb_ack_o}, 0);
      chk("rst_rdata", bus.wb_rdata_o, 0);
      chk("rst_irq", {31'b0, irq}, 0);
      @(posedge clk); #1 rst = 1'b0;

      // Dirty some state, then abort a read with reset.
      wr32(8'h0C, 32'h55);
      wr32(8'h04, 32'h9);
      wr32(8'h00, 32'h4);
      bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_wr_en_i = 0; bus.wb_addr_i = 32'h0C;
      @(negedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
      @(negedge clk);
      chk("abort_ack", {31'b0, bus.wb_ack_o}, 0);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 6; i++) rd32(8'(4*i), 32'h0);
      chk("post_rst_irq", {31'b0, irq}, 0);

      // Byte enables
      wr32(8'h0C, 32'hAABBCCDD);
      xfer(1'b1, 8'h0C, 4'b0101, 32'h11223344, 32'h0);
      rd32(8'h0C, 32'hAA22CC44);
      wr32(8'h04, 32'hFFFFFFFF);
      rd32(8'h04, 32'h0000FFFF);
      wr32(8'h00, 32'hFFFFFFF8);
      rd32(8'h00, 32'h0);

      // Prescaled count: ticks every 4th edge after enable, disable lands
      // on the 42nd edge -> 10 ticks.
      wr32(8'h04, 32'd3);
      wr32(8'h08, 32'd0);
      wr32(8'h0C, 32'hFFFFFFFF);
      wr32(8'h00, 32'h1);
      idle(40);
      wr32(8'h00, 32'h0);
      rd32(8'h08, 32'd10);

      // Auto-reload with interrupt, CMP=5: period 6.
      wr32(8'h04, 32'd0);
      wr32(8'h08, 32'd0);
      wr32(8'h0C, 32'd5);
      wr32(8'h00, 32'h7);             // edge N
      wait_irq("irq_first_rise", 6);  // now just after N+7
      rd32(8'h08, 32'd1);             // sampled N+8
      rd32(8'h08, 32'd3);             // N+10
      rd32(8'h08, 32'd5);             // N+12
      idle(1);
      rd32(8'h08, 32'd2);             // N+15
      rd32(8'h08, 32'd4);             // N+17
      rd32(8'h08, 32'd0);             // N+19
      idle(3);
      wr32(8'h10, 32'h1);             // N+24 is a match edge
      chk("w1c_vs_match", {31'b0, irq_at_ack}, 1);
      wr32(8'h10, 32'h1);             // N+26
      chk("irq_drop", {31'b0, irq_at_ack}, 0);
      chk("irq_low_after", {31'b0, irq}, 0);
      wait_irq("irq_rerise", 4);      // next match at N+30
      rd32(8'h10, 32'h1);
      wr32(8'h00, 32'h0);

      // Wrap without reload
      wr32(8'h08, 32'hFFFFFFFE);
      wr32(8'h0C, 32'hFFFFFFFF);
      wr32(8'h10, 32'h1);
      rd32(8'h10, 32'h0);
      wr32(8'h00, 32'h1);             // edge W
      idle(1);
      rd32(8'h08, 32'h0);             // state after W+2
      rd32(8'h10, 32'h1);
      chk("wrap_irq_masked", {31'b0, irq}, 0);
      wr32(8'h00, 32'h0);

      // COUNT write collides with a tick
      wr32(8'h04, 32'd7);
      wr32(8'h08, 32'd0);
      wr32(8'h10, 32'h1);
      wr32(8'h00, 32'h1);             // edge E0, ticks at E0+8k
      idle(6);
      wr32(8'h08, 32'h100);           // E0+8
      rd32(8'h08, 32'h100);           // E0+10
      wr32(8'h00, 32'h0);
      rd32(8'h08, 32'h100);

      // Unmapped offsets
      wr32(8'h18, 32'hDEADBEEF);
      rd32(8'h18, 32'h0);
      rd32(8'h1C, 32'h0);

      idle(2);
      chk("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_timer.md
# wb_timer

Wishbone classic slave timer peripheral that sits directly downstream of the OBI-to-Wishbone bridge on the core's data bus. It provides a prescaled 32-bit up-counter, a compare register, an optional auto-reload, and a level interrupt. All registers are accessed through single-transfer Wishbone cycles issued by the bridge.

## Interface
- `ADDR_W`, default 32: Wishbone address width.
- `DATA_W`, default 32: Wishbone data width. It is fixed at 32 for this block.
- `PRESC_W`, default 16: prescaler register width.

Ports:
- `wb_clk_i`, input, 1: the single clock. All logic is on the rising edge.
- `rst_i`, input, 1: reset. Asynchronous and active-high.
- `wb_cyc_i`, input, 1: bus cycle active.
- `wb_stb_i`, input, 1: transfer strobe.
- `wb_addr_i`, input, `ADDR_W`: byte address. Only bits [4:2] are decoded.
- `wb_wr_en_i`, input, 1: 1 selects write, 0 selects read.
- `wb_byte_en_i`, input, `DATA_W/8`: per-byte write enable.
- `wb_wdata_i`, input, `DATA_W`: write data.
- `wb_rdata_o`, output, `DATA_W`: read data. Valid only while `wb_ack_o` is high.
- `wb_ack_o`, output, 1: transfer acknowledge, a 1-cycle pulse.
- `irq_o`, output, 1: level interrupt.

## Operation
Register map (offset, name, fields):
- 0x00 `CTRL`:
  - bit0 `EN`: counter enable.
  - bit1 `AR`: auto-reload.
  - bit2 `IE`: interrupt enable.
  - Other bits read 0.
- 0x04 `PRESC`: bits [PRESC_W-1:0]. The counter advances once every PRESC+1 clocks.
- 0x08 `COUNT`: 32-bit counter, read/write.
- 0x0C `CMP`: 32-bit compare value, read/write.
- 0x10 `STATUS`: bit0 `MATCH`, write-1-to-clear. Writing 0 has no effect.
- 0x14 to 0x1C: unmapped. Reads return 0, writes are ignored, and the access is still acknowledged.

Bus access:
- A write updates only the bytes whose `wb_byte_en_i` bit is 1.
- A read ignores `wb_byte_en_i`.

Bus slave state machine:
- `IDLE`:
  - If `wb_cyc_i & wb_stb_i` is high, go to `ACK` on the next edge.
  - On that same edge: perform the write, or latch the read data into `wb_rdata_o`.
- `ACK`:
  - `wb_ack_o` = 1 for exactly one cycle, then return to `IDLE`.
  - The strobe is not re-sampled while in `ACK`, so one request never yields a double acknowledge.
- When not acknowledging, `wb_rdata_o` is driven to 0.

Tick generation:
- While `EN` = 1, the prescaler counter `pcnt` increments every clock.
- When `pcnt == PRESC`: `pcnt` becomes 0 and a tick occurs.
- While `EN` = 0: `pcnt` is held at 0 and no ticks occur.

On each tick:
- If `COUNT == CMP`:
  - `MATCH` is set.
  - `COUNT` becomes 0 if `AR` = 1.
  - Otherwise `COUNT` becomes `COUNT+1`.
- Else `COUNT` becomes `COUNT+1`.
- Increment is modulo 2^32, so 0xFFFFFFFF wraps to 0.

Interrupt:
- `irq_o = MATCH & IE`. It is combinational from registered state.

## Timing
Reset (`rst_i` = 1, asynchronous):
- All registers, `pcnt` and the bus state return to 0 / `IDLE`.
- `wb_ack_o` = 0, `wb_rdata_o` = 0, `irq_o` = 0.
- If reset is asserted mid-transfer, the transfer is aborted with no ack.

Bus latency:
- Strobe sampled at edge N; `wb_ack_o` is high during cycle N+1.
- Write effects are visible from edge N.
- Read data reflects register state just before edge N.

Simultaneous events:
- Bus write to `COUNT` and a tick on the same edge: the bus write wins and the tick's increment is lost.
- Bus write to `PRESC` or `CTRL` and a tick on the same edge: the tick uses the old values; the new values apply from the next cycle.
- W1C of `MATCH` and a new match on the same edge: set wins, so `MATCH` stays 1.
- Writing `EN` = 0 clears `pcnt` on that edge, and no tick occurs on that edge.

Compare behaviour:
- The compare uses the pre-increment `COUNT`.
- With `PRESC` = 0 and `AR` = 1, `COUNT` cycles 0..CMP, giving a period of CMP+1 clocks.

## Test plan
- Reset and read-back:
  - Stimulus: assert `rst_i` mid-read, then read all six offsets.
  - Required: all reads return 0; `irq_o` = 0; each ack lasts exactly 1 cycle, arriving 1 cycle after the strobe.
- Byte enables:
  - Stimulus: write `CMP` = 0xAABBCCDD with byte_en 4'b1111, then write 0x11223344 with byte_en 4'b0101.
  - Required: `CMP` reads back 0xAA22CC44.
- Prescaled count:
  - Stimulus: `PRESC` = 3, `COUNT` = 0, `CMP` = 0xFFFFFFFF, `CTRL` = 0x1; wait 40 clocks, then clear `EN`.
  - Required: `COUNT` = 10.
- Auto-reload interrupt:
  - Stimulus: `PRESC` = 0, `CMP` = 5, `CTRL` = 0x7.
  - Required: `irq_o` rises 6 ticks after enable; `COUNT` sequence is 0,1,2,3,4,5,0.
  - Then write `STATUS` = 0x1: `irq_o` drops the next cycle and rises again 6 ticks later.
- Wrap without reload:
  - Stimulus: `COUNT` = 0xFFFFFFFE, `CMP` = 0xFFFFFFFF, `AR` = 0, `EN` = 1, `PRESC` = 0.
  - Required: `COUNT` reaches 0x00000000 two ticks later; `MATCH` = 1.
- Collisions:
  - Write `COUNT` = 0x100 on a tick edge: it reads back 0x100.
  - W1C `STATUS` on the match edge: `MATCH` stays 1.
  - Access to offset 0x18: acked, and the read returns 0.
